// File: rtl/one_bit_shifter.sv
// Purpose: single-bit shift unit; combinational LSL-by-1 path plus a loadable shift register.
// Latency: shifted/zero are combinational; q and carry_out update one clock after load/shift_en.
// Backpressure: none; every cycle with load or shift_en high is consumed unconditionally.
module one_bit_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] to_shift,
  output logic [WIDTH-1:0] shifted,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             shift_en,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             zero
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_e;

  logic [WIDTH-1:0] shift_q_dat;
  logic             shift_carry_dat;
  logic [WIDTH-1:0] next_q;
  logic             next_carry;

  // Combinational datapath shift: MSB drops off, LSB filled with zero.
  always_comb begin
    shifted = {to_shift[WIDTH-2:0], 1'b0};
  end

  // One-bit shift of the register contents for the selected mode; the
  // outgoing bit becomes the carry. Only consulted when a shift happens,
  // so an undriven mode while idle never reaches the state.
  always_comb begin
    shift_q_dat     = q;
    shift_carry_dat = carry_out;
    unique case (shift_mode_e'(mode))
      MODE_LSL: begin
        shift_q_dat     = {q[WIDTH-2:0], 1'b0};
        shift_carry_dat = q[WIDTH-1];
      end
      MODE_LSR: begin
        shift_q_dat     = {1'b0, q[WIDTH-1:1]};
        shift_carry_dat = q[0];
      end
      MODE_ASR: begin
        shift_q_dat     = {q[WIDTH-1], q[WIDTH-1:1]};
        shift_carry_dat = q[0];
      end
      MODE_ROL: begin
        shift_q_dat     = {q[WIDTH-2:0], q[WIDTH-1]};
        shift_carry_dat = q[WIDTH-1];
      end
      default: begin
        shift_q_dat     = q;
        shift_carry_dat = carry_out;
      end
    endcase
  end

  // Next-state select: load beats shift, otherwise hold.
  always_comb begin
    next_q     = q;
    next_carry = carry_out;
    if (load) begin
      next_q     = to_shift;
      next_carry = 1'b0;
    end else if (shift_en) begin
      next_q     = shift_q_dat;
      next_carry = shift_carry_dat;
    end
  end

  // Register state; reset clears contents immediately, regardless of clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      carry_out <= 1'b0;
    end else begin
      q         <= next_q;
      carry_out <= next_carry;
    end
  end

  // Zero flag follows q directly rather than being stored.
  always_comb begin
    zero = (q == '0);
  end

endmodule

// File: tb/tb_one_bit_shifter.sv
module tb_one_bit_shifter;

  localparam int WIDTH = 16;

  logic             clk;
  logic             clk_run;
  logic             rst_n;
  logic [WIDTH-1:0] to_shift;
  logic [WIDTH-1:0] shifted;
  logic [1:0]       mode;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] q;
  logic             carry_out;
  logic             zero;

  int checks;
  int failures;

  one_bit_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .to_shift  (to_shift),
    .shifted   (shifted),
    .mode      (mode),
    .load      (load),
    .shift_en  (shift_en),
    .q         (q),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic             rst_n;
    logic [WIDTH-1:0] to_shift;
    logic [WIDTH-1:0] exp_shifted;
  } comb_vec_t;

  typedef struct {
    string            name;
    logic             load;
    logic             shift_en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] to_shift;
    logic [WIDTH-1:0] exp_q;
    logic             exp_carry;
    logic             exp_zero;
  } reg_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [WIDTH-1:0] eq,
                           input logic ec, input logic ez);
    chk({name, ".q"}, 32'(q), 32'(eq));
    chk({name, ".carry"}, 32'(carry_out), 32'(ec));
    chk({name, ".zero"}, 32'(zero), 32'(ez));
  endtask

  comb_vec_t comb_tbl[6];
  reg_vec_t  reg_tbl[16];

  initial begin
    checks   = 0;
    failures = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b0;
    to_shift = '0;
    mode     = 2'b00;
    load     = 1'b0;
    shift_en = 1'b0;

    comb_tbl[0] = '{1'b0, 16'd0,     16'd0};
    comb_tbl[1] = '{1'b0, 16'd1,     16'd2};
    comb_tbl[2] = '{1'b1, 16'd2,     16'd4};
    comb_tbl[3] = '{1'b1, 16'd16,    16'd32};
    comb_tbl[4] = '{1'b1, 16'd65535, 16'd65534};
    comb_tbl[5] = '{1'b0, 16'h8001,  16'h0002};

    //            name         ld    sh    mode   to_shift  exp_q     c     z
    reg_tbl[0]  = '{"ld8001",  1'b1, 1'b0, 2'b00, 16'h8001, 16'h8001, 1'b0, 1'b0};
    reg_tbl[1]  = '{"lsl",     1'b0, 1'b1, 2'b00, 16'h0000, 16'h0002, 1'b1, 1'b0};
    reg_tbl[2]  = '{"ld8001b", 1'b1, 1'b0, 2'b11, 16'h8001, 16'h8001, 1'b0, 1'b0};
    reg_tbl[3]  = '{"rol",     1'b0, 1'b1, 2'b11, 16'h0000, 16'h0003, 1'b1, 1'b0};
    reg_tbl[4]  = '{"ld8002",  1'b1, 1'b0, 2'b10, 16'h8002, 16'h8002, 1'b0, 1'b0};
    reg_tbl[5]  = '{"asr",     1'b0, 1'b1, 2'b10, 16'h0000, 16'hC001, 1'b0, 1'b0};
    reg_tbl[6]  = '{"ld8002b", 1'b1, 1'b0, 2'b01, 16'h8002, 16'h8002, 1'b0, 1'b0};
    reg_tbl[7]  = '{"lsr",     1'b0, 1'b1, 2'b01, 16'h0000, 16'h4001, 1'b0, 1'b0};
    reg_tbl[8]  = '{"ld_prio", 1'b1, 1'b1, 2'b00, 16'h00F0, 16'h00F0, 1'b0, 1'b0};
    reg_tbl[9]  = '{"hold1",   1'b0, 1'b0, 2'b00, 16'h1111, 16'h00F0, 1'b0, 1'b0};
    reg_tbl[10] = '{"hold2",   1'b0, 1'b0, 2'b11, 16'h2222, 16'h00F0, 1'b0, 1'b0};
    reg_tbl[11] = '{"hold3",   1'b0, 1'b0, 2'b01, 16'h3333, 16'h00F0, 1'b0, 1'b0};
    reg_tbl[12] = '{"ldFFFF",  1'b1, 1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    reg_tbl[13] = '{"lsl_ff",  1'b0, 1'b1, 2'b00, 16'h0000, 16'hFFFE, 1'b1, 1'b0};
    reg_tbl[14] = '{"ld8000",  1'b1, 1'b0, 2'b10, 16'h8000, 16'h8000, 1'b0, 1'b0};
    reg_tbl[15] = '{"asr_8k",  1'b0, 1'b1, 2'b10, 16'h0000, 16'hC000, 1'b0, 1'b0};

    // Reset state with the clock idle.
    #3;
    chk_state("reset_init", 16'h0000, 1'b0, 1'b1);

    // Combinational path, clock idle, reset in either state.
    foreach (comb_tbl[i]) begin
      rst_n    = comb_tbl[i].rst_n;
      to_shift = comb_tbl[i].to_shift;
      #5;
      chk($sformatf("comb%0d", i), 32'(shifted), 32'(comb_tbl[i].exp_shifted));
    end

    // Start clocking with reset released.
    rst_n   = 1'b1;
    #2;
    clk_run = 1'b1;
    step();

    // Asynchronous reset mid-cycle wipes a loaded value before any edge.
    load = 1'b1; to_shift = 16'h1234;
    step();
    load = 1'b0;
    chk_state("pre_rst", 16'h1234, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 16'h0000, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    step();
    chk_state("post_rst", 16'h0000, 1'b0, 1'b1);

    // Table-driven registered-path vectors, one clock per row.
    foreach (reg_tbl[i]) begin
      load     = reg_tbl[i].load;
      shift_en = reg_tbl[i].shift_en;
      mode     = reg_tbl[i].mode;
      to_shift = reg_tbl[i].to_shift;
      step();
      chk_state(reg_tbl[i].name, reg_tbl[i].exp_q, reg_tbl[i].exp_carry, reg_tbl[i].exp_zero);
    end

    // Undriven mode while idle must not disturb state.
    load = 1'b0; shift_en = 1'b0; mode = 2'bxx;
    step();
    chk_state("hold_xmode", 16'hC000, 1'b0, 1'b0);

    // LSR drains 0x8002 to zero after 16 shifts; last bit out is a 1.
    load = 1'b1; mode = 2'b01; to_shift = 16'h8002;
    step();
    load = 1'b0; shift_en = 1'b1;
    step();
    chk_state("lsr_first", 16'h4001, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) step();
    chk_state("lsr_15", 16'h0001, 1'b0, 1'b0);
    step();
    chk_state("lsr_16", 16'h0000, 1'b1, 1'b1);
    shift_en = 1'b0;

    // Mode changing between consecutive shifts: LSL then LSR then ROL.
    load = 1'b1; to_shift = 16'h4003;
    step();
    load = 1'b0; shift_en = 1'b1; mode = 2'b00;
    step();
    chk_state("mix_lsl", 16'h8006, 1'b0, 1'b0);
    mode = 2'b01;
    step();
    chk_state("mix_lsr", 16'h4003, 1'b0, 1'b0);
    mode = 2'b11;
    step();
    chk_state("mix_rol", 16'h8006, 1'b0, 1'b0);
    step();
    chk_state("mix_rol2", 16'h000D, 1'b1, 1'b0);
    shift_en = 1'b0;

    // All-ones rotate for a full width stays all-ones with carry set.
    load = 1'b1; to_shift = 16'hFFFF;
    step();
    load = 1'b0; shift_en = 1'b1; mode = 2'b11;
    for (int k = 0; k < WIDTH; k++) begin
      step();
      chk_state($sformatf("rol_wrap%0d", k), 16'hFFFF, 1'b1, 1'b0);
    end
    shift_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/one_bit_shifter.md
Name: one_bit_shifter

Overview:
Single-bit shift unit for the 16-bit processor datapath.
- Combinational path `shifted`: always presents the operand shifted left by one.
- Registered path `q`: a shift register that can be loaded, then shifted one bit per enabled clock in a selectable mode. It reports the bit shifted out and a zero flag for the ALU/flag logic.

Parameters:
WIDTH, 16, datapath width in bits (all data ports use this width).

Ports:
- clk  input  1  system clock; registered state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- to_shift  input  WIDTH  operand for the combinational path; load data for the register.
- shifted  output  WIDTH  combinational logical-shift-left-by-1 of to_shift.
- mode  input  2  registered shift mode: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- load  input  1  q <= to_shift on the next rising edge.
- shift_en  input  1  shift q by one bit on the next rising edge, per mode.
- q  output  WIDTH  registered shift-register contents.
- carry_out  output  1  registered; the bit most recently shifted out of q.
- zero  output  1  combinational; high when q == 0.

Behaviour:
Combinational path:
- shifted = {to_shift[WIDTH-2:0], 1'b0}. The MSB is discarded and the LSB is forced to 0.
- No dependence on clk, rst_n, mode, load or shift_en.
- Output settles within the same delta/propagation time, with no latency.

Reset:
- rst_n low asynchronously forces q = 0 and carry_out = 0, so zero = 1.
- Reset dominates load and shift_en.
- Reset asserted mid-operation discards the current contents immediately.
- Release is synchronized by the next rising edge; no special deassertion behaviour is required beyond normal flop sampling.

Registered path, evaluated at each rising clk edge while rst_n is high:
- load = 1:
  - q <= to_shift.
  - carry_out <= 0.
  - Load has priority over shift_en when both are high.
- load = 0, shift_en = 1, by mode:
  - LSL (00): q <= {q[W-2:0], 0}; carry_out <= q[W-1].
  - LSR (01): q <= {0, q[W-1:1]}; carry_out <= q[0].
  - ASR (10): q <= {q[W-1], q[W-1:1]}, i.e. sign preserved; carry_out <= q[0].
  - ROL (11): q <= {q[W-2:0], q[W-1]}; carry_out <= q[W-1].
- load = 0, shift_en = 0: q and carry_out hold.

Timing and boundaries:
- Latency: one clock from the load/shift_en sample to the updated q and carry_out.
- Exactly one bit of shift per enabled cycle. Continuous shift_en shifts once per cycle.
- `mode` is sampled only on cycles where a shift occurs. Changing mode between cycles is legal.
- Boundary cases:
  - All-ones under LSL gives 0xFFFE, carry 1.
  - All-ones under ROL stays 0xFFFF, carry 1.
  - 0x8000 under ASR gives 0xC000.
  - After WIDTH LSL/LSR shifts any value reaches 0.
- zero tracks q combinationally and is never registered separately.
- No X propagation from an undriven mode when shift_en = 0.

Test Plan:
1. Combinational: to_shift = 0, 1, 2, 16, 65535 -> shifted = 0, 2, 4, 32, 65534. Check 5 ns after each change, with clk idle and rst_n in either state.
2. Reset: load 0x1234, then pulse rst_n low between clock edges -> q = 0, carry_out = 0, zero = 1 immediately, before any clock edge.
3. LSL/ROL: load 0x8001.
   - One LSL cycle -> q = 0x0002, carry_out = 1.
   - Reload 0x8001, one ROL cycle -> q = 0x0003, carry_out = 1.
4. LSR/ASR: load 0x8002.
   - One ASR cycle -> q = 0xC001, carry_out = 0.
   - Reload, one LSR cycle -> q = 0x4001, carry_out = 0.
   - Then 15 more LSR cycles -> q = 0, zero = 1.
5. Priority/hold: load = 1 and shift_en = 1 with to_shift = 0x00F0 -> q = 0x00F0, carry_out = 0. Then both low for 3 cycles -> q holds 0x00F0.
6. Wrap: load 0xFFFF, ROL for 16 cycles -> q stays 0xFFFF, carry_out = 1 every cycle, zero never asserts.
